// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared load/store codes, error codes and FSM states for the data-memory sequencer
package dmem_access_ctrl_pkg;
  localparam logic [2:0] LT_NOREGWRITE = 3'd0;
  localparam logic [2:0] LT_LB         = 3'd1;
  localparam logic [2:0] LT_LH         = 3'd2;
  localparam logic [2:0] LT_LW         = 3'd3;
  localparam logic [2:0] LT_LBU        = 3'd4;
  localparam logic [2:0] LT_LHU        = 3'd5;
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;
  // Access size of a load code; SZ_ILLEGAL marks codes that are not loads.
  function automatic logic [1:0] load_size(input logic [2:0] lt);
    return (lt == LT_LB || lt == LT_LBU) ? SZ_BYTE :
           (lt == LT_LH || lt == LT_LHU) ? SZ_HALF :
           (lt == LT_LW) ? SZ_WORD : SZ_ILLEGAL;
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// dmem_lane_align: legality/alignment checks, byte enables and lane-replicated store data
// Ports: we/load_type/store_size/addr/data in; illegal, misaligned, be, wdata out.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_size,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata
);
  logic [1:0] size;
  always_comb begin
    size       = we ? store_size : load_size(load_type);
    illegal    = size == SZ_ILLEGAL;
    misaligned = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    be         = size == SZ_BYTE ? 4'b0001 << addr :
                 size == SZ_HALF ? 4'b0011 << addr :
                 size == SZ_WORD ? 4'b1111 : 4'b0000;
    wdata      = size == SZ_BYTE ? {4{data[7:0]}} :
                 size == SZ_HALF ? {2{data[15:0]}} : data;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: one-at-a-time load/store sequencer between MEM stage and a variable-latency word memory
// Ports: req_* request from MEM (req_ready back), mem_* memory side, resp_* one-cycle response to WB, stall to pipeline.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_type,
  input  logic [1:0]  req_store_size,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_byte_sel,
  output logic [2:0]  resp_load_type,
  output logic [1:0]  resp_err,
  output logic        stall
);
  state_e      state, nxt;
  logic [15:0] cnt;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [29:0] addr_q;
  logic        illegal, misaligned, bad, accept, timeout;
  logic [3:0]  be;
  logic [31:0] wdata;

  dmem_lane_align u_align (
    .we(req_we),
    .load_type(req_load_type),
    .store_size(req_store_size),
    .addr(req_addr[1:0]),
    .data(req_wdata),
    .illegal(illegal),
    .misaligned(misaligned),
    .be(be),
    .wdata(wdata)
  );

  always_comb begin
    bad     = illegal | misaligned;
    accept  = state == S_IDLE && req_valid;
    timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
    nxt     = state == S_IDLE ? (req_valid ? (bad ? S_RESP : S_WAIT) : S_IDLE) :
              state == S_WAIT ? ((mem_ack || timeout) ? S_RESP : S_WAIT) : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      we_q           <= 1'b0;
      be_q           <= '0;
      wdata_q        <= '0;
      addr_q         <= '0;
      resp_rdata     <= '0;
      resp_byte_sel  <= '0;
      resp_load_type <= LT_NOREGWRITE;
      resp_err       <= ERR_OK;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt            <= '0;
        we_q           <= req_we;
        be_q           <= be;
        wdata_q        <= wdata;
        addr_q         <= req_addr[31:2];
        resp_rdata     <= '0;
        resp_byte_sel  <= req_addr[1:0];
        resp_load_type <= (req_we || bad) ? LT_NOREGWRITE : req_load_type;
        resp_err       <= illegal ? ERR_ILLEGAL : misaligned ? ERR_MISALIGN : ERR_OK;
      end
      if (state == S_WAIT) begin
        cnt <= cnt + 16'd1;
        // ack takes priority over a timeout landing on the same cycle
        if (mem_ack) begin
          resp_rdata <= we_q ? 32'd0 : mem_rdata;
          resp_err   <= ERR_OK;
        end else if (timeout) begin
          resp_err       <= ERR_TIMEOUT;
          resp_load_type <= LT_NOREGWRITE;
        end
      end
    end
  end

  always_comb begin
    req_ready  = state == S_IDLE;
    mem_en     = state == S_WAIT;
    mem_we     = (mem_en && we_q) ? be_q : 4'b0000;
    mem_addr   = mem_en ? {addr_q, 2'b00} : 32'd0;
    mem_wdata  = (mem_en && we_q) ? wdata_q : 32'd0;
    resp_valid = state == S_RESP;
    stall      = accept || state == S_WAIT;
  end
endmodule
